sr_cmd_sequencer: RTL and testbench

- Clocked command front-end directly upstream of the 2-bit SR latch cell: converts valid/ready commands into SET/CLR pulse sequences.
- Fixed pulse width and guard gap; SET and CLR are never asserted on the same bit.
- Optionally reads back the latch's Q and flags a mismatch against the expected value.
- Serves as a sequential DuRTL test cell whose flow from command inputs through SET/CLR and back via Q is trackable.

---
 rtl/sr_seq_pkg.sv | 30 +++
 rtl/sr_seq_timer.sv | 27 ++
 rtl/sr_cmd_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sr_seq_pkg.sv
// Shared types and helpers for the SR latch command sequencer.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } sr_state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_TOG = 2'b11
  } sr_op_e;

  // Per-bit expected latch value after a command; a zero mask bit keeps Qa.
  function automatic logic sr_exp_bit(input sr_op_e op, input logic m, input logic qa);
    logic r;
    case (op)
      OP_SET:  r = qa | m;
      OP_CLR:  r = qa & ~m;
      OP_TOG:  r = qa ^ m;
      default: r = qa;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sr_seq_timer.sv
// Loadable down-counter with zero flag; saturates at zero.
module sr_seq_timer #(
  parameter int CW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Valid/ready command front-end producing SET/CLR pulse sequences for an SR latch.
// Optional Q readback mismatch flag enabled by defining SR_READBACK_CHECK_EN.
module sr_cmd_sequencer
  import sr_seq_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_mask_i,
  output logic [WIDTH-1:0] set_o,
  output logic [WIDTH-1:0] clr_o,
  input  logic [WIDTH-1:0] q_i,
  output logic             done_o,
  output logic             err_o
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // Timer holds "remaining cycles minus one" so zero marks the last cycle of a phase.
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sr_state_e state_q, state_d;
  logic [WIDTH-1:0] set_q, set_d, clr_q, clr_d;
  logic [WIDTH-1:0] drv_set, drv_clr;
  logic done_q, done_d;
  logic accept, do_pulse;
  logic tmr_load, tmr_zero;
  logic [CW-1:0] tmr_val;
  sr_op_e op;

  assign op       = sr_op_e'(cmd_op_i);
  assign accept   = cmd_valid_i && (state_q == ST_IDLE);
  assign do_pulse = (op != OP_NOP) && (cmd_mask_i != '0);

  sr_seq_timer #(.CW(CW)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Drive pattern taken from the command and Q at the accept edge.
  always_comb begin
    drv_set = '0;
    drv_clr = '0;
    case (op)
      OP_SET:  drv_set = cmd_mask_i;
      OP_CLR:  drv_clr = cmd_mask_i;
      OP_TOG: begin
        drv_set = cmd_mask_i & ~q_i;
        drv_clr = cmd_mask_i &  q_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
      clr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = PULSE_LD;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (do_pulse) begin
            state_d  = ST_PULSE;
            tmr_load = 1'b1;
          end else begin
            state_d  = ST_CHECK;
          end
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          if (GAP_CYCLES == 0) begin
            state_d  = ST_CHECK;
          end else begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end
        end
      end
      ST_GAP:   if (tmr_zero) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    set_d  = '0;
    clr_d  = '0;
    done_d = (state_d == ST_CHECK);
    if (state_q == ST_IDLE && state_d == ST_PULSE) begin
      set_d = drv_set;
      clr_d = drv_clr;
    end else if (state_q == ST_PULSE && state_d == ST_PULSE) begin
      set_d = set_q;
      clr_d = clr_q;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign set_o       = set_q;
  assign clr_o       = clr_q;
  assign done_o      = done_q;

`ifdef SR_READBACK_CHECK_EN
  logic [WIDTH-1:0] exp_q, exp_d, mask_q;
  logic err_q, err_d;

  for (genvar b = 0; b < WIDTH; b++) begin : g_exp
    assign exp_d[b] = sr_exp_bit(op, cmd_mask_i[b], q_i[b]);
  end

  always_comb begin
    err_d = err_q;
    if (accept)                   err_d = 1'b0;
    else if (state_q == ST_CHECK) err_d = ((q_i ^ exp_q) & mask_q) != '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q  <= '0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (accept) begin
        exp_q  <= exp_d;
        mask_q <= cmd_mask_i;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer driving a behavioural SR latch; reference model per command.
module tb_sr_cmd_sequencer;
  localparam int W = 2, P = 4, G = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready, done, err;
  logic [1:0] cmd_op;
  logic [W-1:0] cmd_mask, set_v, clr_v, q, q_load_val;
  logic q_load, q_hold;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  // SR latch cell (CLR dominant, never both by contract); q_hold models a stuck latch.
  always @(posedge clk)
    if (q_load)       q <= q_load_val;
    else if (!q_hold) q <= (q | set_v) & ~clr_v;

  sr_cmd_sequencer #(.WIDTH(W), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_mask_i(cmd_mask), .set_o(set_v), .clr_o(clr_v),
    .q_i(q), .done_o(done), .err_o(err)
  );

  function automatic logic [W-1:0] ref_set(input logic [1:0] op, input logic [W-1:0] m, input logic [W-1:0] qa);
    if (op == 2'b01) return m;
    if (op == 2'b11) return m & ~qa;
    return '0;
  endfunction

  function automatic logic [W-1:0] ref_clr(input logic [1:0] op, input logic [W-1:0] m, input logic [W-1:0] qa);
    if (op == 2'b10) return m;
    if (op == 2'b11) return m & qa;
    return '0;
  endfunction

  function automatic logic [W-1:0] ref_exp(input logic [1:0] op, input logic [W-1:0] m, input logic [W-1:0] qa);
    case (op)
      2'b01:   return qa | m;
      2'b10:   return qa & ~m;
      2'b11:   return qa ^ m;
      default: return qa;
    endcase
  endfunction

  function automatic int ref_len(input logic [1:0] op, input logic [W-1:0] m);
    return (op == 2'b00 || m == '0) ? 1 : P + G + 1;
  endfunction

  function automatic logic ref_err(input logic [W-1:0] qc, input logic [W-1:0] ex, input logic [W-1:0] m);
`ifdef SR_READBACK_CHECK_EN
    return ((qc ^ ex) & m) != '0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mask = '0;
    q_hold = 1'b0; q_load = 1'b1; q_load_val = '0;
    repeat (2) @(negedge clk);
    q_load = 1'b0;
    total++; if ({cmd_ready, done, err, set_v, clr_v} !== {3'b100, {2*W{1'b0}}}) begin
      bad++; $display("FAIL reset_state got rdy/done/err/set/clr=%b%b%b %b %b exp 100 00 00", cmd_ready, done, err, set_v, clr_v); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    // Reset asserted in the second pulse cycle of a SET command.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_mask = 2'b11;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (set_v !== 2'b11) begin bad++; $display("FAIL rst_pre_set got=%b exp=11", set_v); end
    rst_n = 1'b0;
    #1;
    total++; if ({set_v, clr_v} !== '0) begin bad++; $display("FAIL rst_async_drop got set=%b clr=%b exp 00 00", set_v, clr_v); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < P + G + 3; k++) begin
      @(negedge clk);
      total++; if ({done, cmd_ready, set_v, clr_v} !== {2'b01, {2*W{1'b0}}}) begin
        bad++; $display("FAIL rst_post k=%0d got done=%b rdy=%b set=%b clr=%b exp 0 1 00 00", k, done, cmd_ready, set_v, clr_v); end
    end
  endtask

  task automatic test_cmd(input string name, input logic [1:0] op, input logic [W-1:0] m,
                          input logic [W-1:0] qinit, input logic hold);
    logic [W-1:0] qa, sd, cd, ex;
    logic eerr;
    int L;
    q_hold = hold; q_load = 1'b1; q_load_val = qinit;
    @(negedge clk);
    q_load = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = m;
    qa = q; sd = ref_set(op, m, qa); cd = ref_clr(op, m, qa); ex = ref_exp(op, m, qa);
    L = ref_len(op, m); eerr = 1'b0;
    for (int k = 1; k <= L + 2; k++) begin
      logic [W-1:0] es, ec;
      @(negedge clk);
      cmd_valid = 1'b0;
      es = (L > 1 && k <= P) ? sd : '0;
      ec = (L > 1 && k <= P) ? cd : '0;
      total++; if (set_v !== es || clr_v !== ec) begin
        bad++; $display("FAIL %s drive k=%0d got set=%b clr=%b exp set=%b clr=%b", name, k, set_v, clr_v, es, ec); end
      total++; if ((set_v & clr_v) !== '0) begin
        bad++; $display("FAIL %s set_and_clr k=%0d got=%b exp=0", name, k, set_v & clr_v); end
      total++; if (done !== (k == L) || cmd_ready !== (k > L)) begin
        bad++; $display("FAIL %s timing k=%0d got done=%b rdy=%b exp done=%b rdy=%b", name, k, done, cmd_ready, k == L, k > L); end
      if (k == L) begin
        eerr = ref_err(q, ex, m);
        if (!hold) begin
          total++; if (q !== ex) begin bad++; $display("FAIL %s q_final got=%b exp=%b", name, q, ex); end
        end
      end
      total++; if (err !== ((k > L) ? eerr : 1'b0)) begin
        bad++; $display("FAIL %s err k=%0d got=%b exp=%b", name, k, err, (k > L) ? eerr : 1'b0); end
    end
    q_hold = 1'b0;
  endtask

  // Free-running random traffic; CMD inputs also toggle while busy and must be ignored.
  task automatic test_random(input string name, input int cycles, input logic hold_valid);
    logic [W-1:0] sd = '0, cd = '0, ex = '0, mk = '0;
    logic merr = 1'b0, pend = 1'b0, err_known = 1'b0;
    int k = 0, L = 1, accepts = 0;
    cmd_valid = 1'b0;
    for (int c = 0; c < cycles || k != 0; c++) begin
      logic [W-1:0] es, ec;
      @(negedge clk);
      es = (k >= 1 && k <= P && L > 1) ? sd : '0;
      ec = (k >= 1 && k <= P && L > 1) ? cd : '0;
      total++; if (set_v !== es || clr_v !== ec || (set_v & clr_v) !== '0) begin
        bad++; $display("FAIL %s drive c=%0d got set=%b clr=%b exp set=%b clr=%b", name, c, set_v, clr_v, es, ec); end
      total++; if (cmd_ready !== (k == 0) || done !== (k != 0 && k == L)) begin
        bad++; $display("FAIL %s handshake c=%0d got rdy=%b done=%b exp rdy=%b done=%b", name, c, cmd_ready, done, k == 0, k != 0 && k == L); end
      if (err_known) begin
        total++; if (err !== merr) begin bad++; $display("FAIL %s err c=%0d got=%b exp=%b", name, c, err, merr); end
      end
      if (k != 0 && k == L) pend = ref_err(q, ex, mk);
      cmd_op = 2'($urandom); cmd_mask = W'($urandom);
      if (k == 0) begin
        cmd_valid = (c < cycles) && (hold_valid || ($urandom_range(0, 1) == 1));
        if (cmd_valid) begin
          sd = ref_set(cmd_op, cmd_mask, q); cd = ref_clr(cmd_op, cmd_mask, q);
          ex = ref_exp(cmd_op, cmd_mask, q); mk = cmd_mask;
          L = ref_len(cmd_op, cmd_mask);
          k = 1; merr = 1'b0; err_known = 1'b1; accepts++;
          q_hold = ($urandom_range(0, 3) == 0);
        end
      end else begin
        cmd_valid = (c < cycles) && (hold_valid || ($urandom_range(0, 1) == 1));
        if (k == L) begin k = 0; merr = pend; end
        else k++;
      end
    end
    cmd_valid = 1'b0; q_hold = 1'b0;
    total++; if (accepts == 0) begin bad++; $display("FAIL %s no_accepts got=0 exp>0", name); end
  endtask

  initial begin
    test_reset();
    test_cmd("set",    2'b01, 2'b11, 2'b00, 1'b0);
    test_cmd("clr",    2'b10, 2'b10, 2'b11, 1'b0);
    test_cmd("toggle", 2'b11, 2'b11, 2'b01, 1'b0);
    test_cmd("rb_err", 2'b01, 2'b01, 2'b00, 1'b1);
    test_cmd("after_err", 2'b10, 2'b01, 2'b11, 1'b0);
    test_cmd("nop",    2'b00, 2'b11, 2'b10, 1'b0);
    test_cmd("mask0",  2'b01, 2'b00, 2'b01, 1'b0);
    test_random("back_to_back", 60, 1'b1);
    test_random("random", 400, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
